// File: rtl/apb_arbiter_ctrl_if.sv
// Bundle of requester handshakes and the shared APB bus for apb_arbiter_ctrl.
// The master modport is the arbiter's view; the slave modport is the view of
// whatever surrounds it (the requesters and the APB slaves).
interface apb_arbiter_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // requester 0
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_err;
  // requester 1
  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_err;
  // shared APB bus
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [1:0]        PSEL;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA0;
  logic [DATA_W-1:0] PRDATA1;
  logic              PREADY0;
  logic              PREADY1;
  logic              PSLVERR0;
  logic              PSLVERR1;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_done, req0_rdata, req0_err,
    output req1_done, req1_rdata, req1_err,
    output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
    input  PRDATA0, PRDATA1, PREADY0, PREADY1, PSLVERR0, PSLVERR1
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_done, req0_rdata, req0_err,
    input  req1_done, req1_rdata, req1_err,
    input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
    output PRDATA0, PRDATA1, PREADY0, PREADY1, PSLVERR0, PSLVERR1
  );
endinterface

// File: rtl/apb_arbiter_ctrl.sv
// Two-requester round-robin APB arbiter with built-in SETUP/ACCESS sequencer.
// Slave 0 (GPIO) lives at addr[31:28]=0x0, slave 1 (UART) at 0x1; any other
// region completes with an error and no bus activity.
// Optional macro APB_TIMEOUT_EN: abort an ACCESS phase that has waited
// TIMEOUT_CYCLES cycles without PREADY, returning an error.
module apb_arbiter_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_arbiter_ctrl_if.master bus
);

  localparam int unsigned DEC_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DECERR = 2'd3
  } state_e;

  state_e            state_q;
  logic [1:0]        psel_q;
  logic              penable_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;
  logic              gnt_q;         // requester owning the current transfer
  logic              last_grant_q;  // most recently granted requester

  logic              any_req;
  logic              pick1;
  logic              pick_write;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic [DEC_W-1:0]  pick_region;

  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              sel_err;
  logic              ack;
  logic              tmo_hit;

  logic              fin;
  logic              fin_err;
  logic [DATA_W-1:0] fin_rdata;

  // Round-robin pick: a tie goes to whoever was not granted last
  always_comb begin
    any_req     = bus.req0_valid | bus.req1_valid;
    pick1       = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    pick_write  = pick1 ? bus.req1_write : bus.req0_write;
    pick_addr   = pick1 ? bus.req1_addr  : bus.req0_addr;
    pick_wdata  = pick1 ? bus.req1_wdata : bus.req0_wdata;
    pick_region = pick_addr[ADDR_W-1 -: DEC_W];
  end

  // Only the selected slave's response is looked at
  always_comb begin
    sel_ready = psel_q[1] ? bus.PREADY1  : bus.PREADY0;
    sel_rdata = psel_q[1] ? bus.PRDATA1  : bus.PRDATA0;
    sel_err   = psel_q[1] ? bus.PSLVERR1 : bus.PSLVERR0;
    ack       = (state_q == S_ACCESS) & sel_ready;
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q == S_ACCESS) & ~sel_ready &
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Wait-state counter: cleared while entering ACCESS, counts stalled cycles
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == S_ACCESS) && !sel_ready && !tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

  // Arbitration / APB sequencer with registered bus outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= S_IDLE;
      psel_q       <= 2'b00;
      penable_q    <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            gnt_q        <= pick1;
            last_grant_q <= pick1;
            paddr_q      <= pick_addr;
            pwdata_q     <= pick_wdata;
            pwrite_q     <= pick_write;
            if (pick_region == DEC_W'(0)) begin
              psel_q  <= 2'b01;
              state_q <= S_SETUP;
            end else if (pick_region == DEC_W'(1)) begin
              psel_q  <= 2'b10;
              state_q <= S_SETUP;
            end else begin
              psel_q  <= 2'b00;
              state_q <= S_DECERR;
            end
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (ack || tmo_hit) begin
            psel_q    <= 2'b00;
            penable_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_DECERR: begin
          state_q <= S_IDLE;
        end
        default: begin
          psel_q    <= 2'b00;
          penable_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  // Completion response is combinational so done lands in the PREADY cycle
  always_comb begin
    fin       = ack | tmo_hit | (state_q == S_DECERR);
    fin_err   = ack ? sel_err : fin;
    fin_rdata = (ack && !pwrite_q) ? sel_rdata : '0;
  end

  // Route the response to the owning requester only
  always_comb begin
    bus.req0_done  = fin & ~gnt_q;
    bus.req0_err   = fin_err & ~gnt_q;
    bus.req0_rdata = gnt_q ? '0 : fin_rdata;
    bus.req1_done  = fin & gnt_q;
    bus.req1_err   = fin_err & gnt_q;
    bus.req1_rdata = gnt_q ? fin_rdata : '0;
  end

  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PWRITE  = pwrite_q;

endmodule

// File: tb/tb_apb_arbiter_ctrl.sv
// Bench for apb_arbiter_ctrl: directed transfers, expected completions queued
// at issue time and checked by an independent done monitor.
module tb_apb_arbiter_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic PCLK;
  logic PRESETn;

  apb_arbiter_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  apb_arbiter_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (ifc.master)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        who;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  psel;
    logic        pen;
    logic [31:0] paddr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic who, input logic [31:0] rdata, input logic err,
                            input logic [1:0] psel, input logic pen, input logic [31:0] paddr);
    exp_t e;
    e.who = who; e.rdata = rdata; e.err = err; e.psel = psel; e.pen = pen; e.paddr = paddr;
    sb.push_back(e);
  endtask

  task automatic set_req(input logic n, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (!n) begin
      ifc.req0_valid = v; ifc.req0_write = w; ifc.req0_addr = a; ifc.req0_wdata = d;
    end else begin
      ifc.req1_valid = v; ifc.req1_write = w; ifc.req1_addr = a; ifc.req1_wdata = d;
    end
  endtask

  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge PCLK);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge PCLK);
      if (n_done >= target) break;
    end
    chk("done_count", 64'(n_done), 64'(target));
    #1;
  endtask

  // Monitor: every done pulse is matched against the oldest expected response
  initial begin
    exp_t e;
    logic who;
    forever begin
      @(negedge PCLK);
      if (PRESETn && (ifc.req0_done || ifc.req1_done)) begin
        chk("single_done", 64'(ifc.req0_done & ifc.req1_done), 64'd0);
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e   = sb.pop_front();
          who = ifc.req1_done;
          chk("who", 64'(who), 64'(e.who));
          chk("rdata", 64'(who ? ifc.req1_rdata : ifc.req0_rdata), 64'(e.rdata));
          chk("err", 64'(who ? ifc.req1_err : ifc.req0_err), 64'(e.err));
          chk("psel_at_done", 64'(ifc.PSEL), 64'(e.psel));
          chk("penable_at_done", 64'(ifc.PENABLE), 64'(e.pen));
          chk("paddr_at_done", 64'(ifc.PADDR), 64'(e.paddr));
          chk("other_side_quiet",
              64'(who ? {ifc.req0_rdata, ifc.req0_err} : {ifc.req1_rdata, ifc.req1_err}), 64'd0);
        end
        n_done++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    PRESETn = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    ifc.PRDATA0 = '0; ifc.PRDATA1 = '0;
    ifc.PREADY0 = 1'b0; ifc.PREADY1 = 1'b0;
    ifc.PSLVERR0 = 1'b0; ifc.PSLVERR1 = 1'b0;

    // reset state
    repeat (2) smp();
    chk("rst_psel", 64'(ifc.PSEL), 64'd0);
    chk("rst_penable", 64'(ifc.PENABLE), 64'd0);
    chk("rst_paddr", 64'(ifc.PADDR), 64'd0);
    chk("rst_pwdata", 64'(ifc.PWDATA), 64'd0);
    chk("rst_pwrite", 64'(ifc.PWRITE), 64'd0);
    chk("rst_done", 64'({ifc.req0_done, ifc.req1_done, ifc.req0_err, ifc.req1_err}), 64'd0);
    PRESETn = 1'b1;

    // single write to GPIO, zero wait states
    cyc();
    set_req(1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_00A5);
    ifc.PREADY0 = 1'b1;
    expect_rsp(1'b0, 32'h0, 1'b0, 2'b01, 1'b1, 32'h0000_0004);
    smp();
    chk("t1_idle_psel", 64'(ifc.PSEL), 64'd0);
    cyc(); smp();
    chk("t1_setup_psel", 64'(ifc.PSEL), 64'h1);
    chk("t1_setup_pen", 64'(ifc.PENABLE), 64'd0);
    chk("t1_paddr", 64'(ifc.PADDR), 64'h4);
    chk("t1_pwdata", 64'(ifc.PWDATA), 64'hA5);
    chk("t1_pwrite", 64'(ifc.PWRITE), 64'd1);
    cyc(); smp();
    chk("t1_access_pen", 64'(ifc.PENABLE), 64'd1);
    cyc();
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();
    chk("t1_end_psel", 64'({ifc.PSEL, ifc.PENABLE}), 64'd0);
    chk("t1_done_cnt", 64'(n_done), 64'd1);

    // fresh reset, then both requesters held: grants alternate 0,1,0,1
    PRESETn = 1'b0;
    smp();
    PRESETn = 1'b1;
    cyc();
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h1000_0008, 32'h0);
    ifc.PRDATA0 = 32'h1111_0000; ifc.PRDATA1 = 32'h2222_0008;
    ifc.PREADY0 = 1'b1; ifc.PREADY1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_rsp(1'b0, 32'h1111_0000, 1'b0, 2'b01, 1'b1, 32'h0000_0000);
      expect_rsp(1'b1, 32'h2222_0008, 1'b0, 2'b10, 1'b1, 32'h1000_0008);
    end
    base = n_done;
    wait_done(base + 4, 30);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();
    chk("t2_end_psel", 64'(ifc.PSEL), 64'd0);

    // req1 read from UART with three wait states; GPIO lines are noise
    cyc();
    set_req(1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    ifc.PREADY1 = 1'b0; ifc.PRDATA1 = 32'h0;
    ifc.PREADY0 = 1'b1; ifc.PSLVERR0 = 1'b1; ifc.PRDATA0 = 32'hBAD0_BAD0;
    expect_rsp(1'b1, 32'hDEAD_BEEF, 1'b0, 2'b10, 1'b1, 32'h1000_0000);
    base = n_done;
    smp();
    cyc(); smp();
    chk("t3_setup", 64'({ifc.PSEL, ifc.PENABLE}), 64'b100);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      chk("t3_wait_bus", 64'({ifc.PSEL, ifc.PENABLE, ifc.PWRITE}), 64'b1010);
      chk("t3_wait_paddr", 64'(ifc.PADDR), 64'h1000_0000);
      chk("t3_wait_nodone", 64'(n_done), 64'(base));
    end
    cyc();
    ifc.PREADY1 = 1'b1; ifc.PRDATA1 = 32'hDEAD_BEEF;
    smp();
    cyc();
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    ifc.PSLVERR0 = 1'b0;
    smp();
    chk("t3_end", 64'({ifc.PSEL, ifc.PENABLE}), 64'd0);
    chk("t3_done_cnt", 64'(n_done), 64'(base + 1));

    // unmapped region: one-cycle error, no select
    cyc();
    set_req(1'b0, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    ifc.PRDATA0 = 32'h1234_5678;
    expect_rsp(1'b0, 32'h0, 1'b1, 2'b00, 1'b0, 32'h2000_0000);
    base = n_done;
    smp();
    cyc(); smp();
    chk("t4_decerr_bus", 64'({ifc.PSEL, ifc.PENABLE}), 64'd0);
    cyc();
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();
    chk("t4_done_cnt", 64'(n_done), 64'(base + 1));

    // UART write with slave error
    cyc();
    set_req(1'b1, 1'b1, 1'b1, 32'h1000_0010, 32'h0000_0055);
    ifc.PREADY1 = 1'b1; ifc.PSLVERR1 = 1'b1; ifc.PRDATA1 = 32'hCAFE_F00D;
    expect_rsp(1'b1, 32'h0, 1'b1, 2'b10, 1'b1, 32'h1000_0010);
    base = n_done;
    smp();
    cyc(); smp();
    chk("t5_pwdata", 64'(ifc.PWDATA), 64'h55);
    cyc(); smp();
    cyc();
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    ifc.PSLVERR1 = 1'b0;
    smp();
    chk("t5_done_cnt", 64'(n_done), 64'(base + 1));

    // reset during ACCESS abandons the transfer; afterwards a tie goes to req0
    cyc();
    set_req(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    ifc.PREADY0 = 1'b0;
    base = n_done;
    smp();
    cyc(); smp();
    cyc(); smp();
    chk("t6_in_access", 64'(ifc.PENABLE), 64'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("t6_async_drop", 64'({ifc.PSEL, ifc.PENABLE, ifc.req0_done}), 64'd0);
    set_req(1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'h0);
    ifc.PREADY0 = 1'b1; ifc.PREADY1 = 1'b1;
    ifc.PRDATA0 = 32'h0000_A0A0; ifc.PRDATA1 = 32'h0000_B1B1;
    smp();
    chk("t6_no_done", 64'(n_done), 64'(base));
    expect_rsp(1'b0, 32'h0000_A0A0, 1'b0, 2'b01, 1'b1, 32'h0000_0004);
    expect_rsp(1'b1, 32'h0000_B1B1, 1'b0, 2'b10, 1'b1, 32'h1000_0004);
    PRESETn = 1'b1;
    wait_done(base + 2, 20);
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();
    chk("t6_end_psel", 64'(ifc.PSEL), 64'd0);

`ifdef APB_TIMEOUT_EN
    // GPIO never ready: error completion on the 16th ACCESS cycle
    begin
      int pen_cnt;
      pen_cnt = 0;
      cyc();
      set_req(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
      ifc.PREADY0 = 1'b0;
      expect_rsp(1'b0, 32'h0, 1'b1, 2'b01, 1'b1, 32'h0000_0000);
      for (int k = 0; k < 40; k++) begin
        smp();
        if (ifc.PENABLE) pen_cnt++;
        if (ifc.req0_done) break;
      end
      chk("tmo_access_cycles", 64'(pen_cnt), 64'd16);
      cyc();
      set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      smp();
      chk("tmo_idle_after", 64'({ifc.PSEL, ifc.PENABLE}), 64'd0);
    end
`endif

    repeat (2) smp();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
